// File: rtl/mmu_router_pkg.sv
// Shared types for the MMU router: FSM states, device limit, wait-count type
// and the select-field width helper.
package mmu_router_pkg;

  localparam int MAX_DEV = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    FAULT
  } state_e;

  typedef logic [3:0] wait_t;

  function automatic int sel_width(input int num_dev);
    return (num_dev > 1) ? $clog2(num_dev) : 1;
  endfunction

endpackage

// File: rtl/mmu_router_if.sv
// CPU-side request/response bus of the MMU router; the CPU is the master.
interface mmu_router_if #(
  parameter int DATA_W = 32
);
  logic              REQ;
  logic              WE;
  logic [31:0]       ADDR;
  logic [DATA_W-1:0] IN;
  logic [DATA_W-1:0] OUT;
  logic              ACK;
  logic              ERR;

  modport master (output REQ, WE, ADDR, IN, input OUT, ACK, ERR);
  modport slave  (input REQ, WE, ADDR, IN, output OUT, ACK, ERR);
endinterface

// File: rtl/mmu_router_decode.sv
// Combinational address decode: device select, range validity and alignment.
// Alignment is only enforced when MMU_ROUTER_ALIGN_CHECK_EN is defined.
module mmu_router_decode
  import mmu_router_pkg::*;
#(
  parameter int NUM_DEV = 2,
  parameter int SEL_LSB = 16,
  parameter int SEL_W   = sel_width(NUM_DEV)
) (
  input  logic [31:0]      addr,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             aligned
);

  // Every address bit above the select field must be zero.
  localparam logic [63:0] HI_MASK64 = ~((64'd1 << (SEL_LSB + SEL_W)) - 64'd1);
  localparam logic [31:0] HI_MASK   = HI_MASK64[31:0];

  assign sel   = addr[SEL_LSB +: SEL_W];
  assign valid = (32'(sel) < 32'(NUM_DEV)) && ((addr & HI_MASK) == 32'd0);

`ifdef MMU_ROUTER_ALIGN_CHECK_EN
  assign aligned = (addr[1:0] == 2'b00);
`else
  assign aligned = 1'b1;
`endif

endmodule

// File: rtl/mmu_router.sv
// Routes single CPU accesses to one of NUM_DEV memory-mapped devices with
// per-device wait states. Optional MMU_ROUTER_ALIGN_CHECK_EN faults misaligned ADDR.
module mmu_router
  import mmu_router_pkg::*;
#(
  parameter int                   NUM_DEV = 2,
  parameter int                   DATA_W  = 32,
  parameter int                   SEL_LSB = 16,
  parameter logic [NUM_DEV*4-1:0] WAIT    = '0
) (
  input  logic                      CLK,
  input  logic                      N_RST,
  mmu_router_if.slave               cpu,
  output logic [NUM_DEV-1:0]        DEV_N_WE,
  output logic [NUM_DEV-1:0]        DEV_N_OE,
  output logic [SEL_LSB-3:0]        DEV_ADDR,
  output logic [DATA_W-1:0]         DEV_IN,
  input  logic [NUM_DEV*DATA_W-1:0] DEV_OUT
);

  localparam int SEL_W = sel_width(NUM_DEV);

  state_e              state_q, state_d;
  wait_t               cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                we_q, we_d;
  logic [SEL_LSB-3:0]  dev_addr_q, dev_addr_d;
  logic [DATA_W-1:0]   dev_in_q, dev_in_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [NUM_DEV-1:0]  n_we_q, n_we_d;
  logic [NUM_DEV-1:0]  n_oe_q, n_oe_d;

  logic [SEL_W-1:0]    dec_sel;
  logic                dec_valid;
  logic                dec_aligned;
  logic [NUM_DEV-1:0]  sel_onehot;
  logic [DATA_W-1:0]   dev_rdata;

  mmu_router_decode #(
    .NUM_DEV (NUM_DEV),
    .SEL_LSB (SEL_LSB),
    .SEL_W   (SEL_W)
  ) u_decode (
    .addr    (cpu.ADDR),
    .sel     (dec_sel),
    .valid   (dec_valid),
    .aligned (dec_aligned)
  );

  assign sel_onehot = NUM_DEV'(1) << dec_sel;
  assign dev_rdata  = DEV_OUT[int'(sel_q)*DATA_W +: DATA_W];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    we_d       = we_q;
    dev_addr_d = dev_addr_q;
    dev_in_d   = dev_in_q;
    out_d      = out_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    n_we_d     = n_we_q;
    n_oe_d     = n_oe_q;

    case (state_q)
      IDLE: begin
        if (cpu.REQ) begin
          we_d       = cpu.WE;
          dev_addr_d = cpu.ADDR[SEL_LSB-1:2];
          dev_in_d   = cpu.IN;
          sel_d      = dec_sel;
          if (dec_valid && dec_aligned) begin
            state_d = ACCESS;
            cnt_d   = WAIT[int'(dec_sel)*4 +: 4];
            if (cpu.WE) n_we_d = ~sel_onehot;
            else        n_oe_d = ~sel_onehot;
          end else begin
            state_d = FAULT;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) out_d = dev_rdata;
          n_we_d  = '1;
          n_oe_d  = '1;
          ack_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - wait_t'(1);
        end
      end
      DONE: state_d = IDLE;
      // The error pulse lands one cycle after FAULT, matching read/ACK latency.
      FAULT: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (N_RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      dev_addr_q <= '0;
      dev_in_q   <= '0;
      out_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      n_we_q     <= '1;
      n_oe_q     <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      dev_addr_q <= dev_addr_d;
      dev_in_q   <= dev_in_d;
      out_q      <= out_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      n_we_q     <= n_we_d;
      n_oe_q     <= n_oe_d;
    end
  end

  assign cpu.OUT  = out_q;
  assign cpu.ACK  = ack_q;
  assign cpu.ERR  = err_q;
  assign DEV_N_WE = n_we_q;
  assign DEV_N_OE = n_oe_q;
  assign DEV_ADDR = dev_addr_q;
  assign DEV_IN   = dev_in_q;

endmodule

// File: tb/tb_mmu_router.sv
// Directed bench for mmu_router: 3 devices with wait states 3/0/5, a vector
// table of single accesses, plus reset-abort and back-to-back sequences.
module tb_mmu_router;

  localparam int          NUM_DEV  = 3;
  localparam int          DATA_W   = 32;
  localparam int          SEL_LSB  = 16;
  localparam logic [11:0] WAIT_CFG = 12'h503;
  localparam logic [31:0] DEV0_VAL = 32'h1111_0000;
  localparam logic [31:0] DEV1_VAL = 32'hDEAD_BEEF;
  localparam logic [31:0] DEV2_VAL = 32'h2222_2222;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  mmu_router_if #(.DATA_W(DATA_W)) cpu_if ();

  logic [NUM_DEV-1:0]        dev_n_we;
  logic [NUM_DEV-1:0]        dev_n_oe;
  logic [SEL_LSB-3:0]        dev_addr;
  logic [DATA_W-1:0]         dev_in;
  logic [NUM_DEV*DATA_W-1:0] dev_out;

  mmu_router #(
    .NUM_DEV (NUM_DEV),
    .DATA_W  (DATA_W),
    .SEL_LSB (SEL_LSB),
    .WAIT    (WAIT_CFG)
  ) dut (
    .CLK      (clk),
    .N_RST    (n_rst),
    .cpu      (cpu_if),
    .DEV_N_WE (dev_n_we),
    .DEV_N_OE (dev_n_oe),
    .DEV_ADDR (dev_addr),
    .DEV_IN   (dev_in),
    .DEV_OUT  (dev_out)
  );

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_dev;
    int          exp_low;
    int          exp_lat;
    logic [31:0] exp_out;
    logic        chk_addr;
    logic [13:0] exp_addr;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic exp_err, input int exp_dev, input int exp_low,
                              input int exp_lat, input logic [31:0] exp_out,
                              input logic chk_addr, input logic [13:0] exp_addr);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.exp_err = exp_err;
    v.exp_dev = exp_dev; v.exp_low = exp_low; v.exp_lat = exp_lat;
    v.exp_out = exp_out; v.chk_addr = chk_addr; v.exp_addr = exp_addr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Strobe exclusivity monitor: at most one active-low strobe in any cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if ($countones(~{dev_n_we, dev_n_oe}) > 1) begin
        bad++;
        $display("[TB] FAIL strobe_overlap: got we=%b oe=%b expected at most one low",
                 dev_n_we, dev_n_oe);
      end
    end
  end

  task automatic applyStimulus(input vec_t v, input int idx);
    int lat_seen = 0;
    int low_seen = 0;
    int ack_cnt  = 0;
    int err_cnt  = 0;
    int wrong    = 0;
    logic [NUM_DEV-1:0] onehot;
    onehot = NUM_DEV'(1) << v.exp_dev;
    @(negedge clk);
    cpu_if.REQ  = 1'b1;
    cpu_if.WE   = v.we;
    cpu_if.ADDR = v.addr;
    cpu_if.IN   = v.wdata;
    @(negedge clk);
    cpu_if.REQ  = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (dev_n_we != '1 || dev_n_oe != '1) begin
        low_seen++;
        if (v.exp_err) wrong++;
        else if (v.we && (dev_n_we != ~onehot || dev_n_oe != '1)) wrong++;
        else if (!v.we && (dev_n_oe != ~onehot || dev_n_we != '1)) wrong++;
      end
      if (cpu_if.ACK) begin
        ack_cnt++;
        if (lat_seen == 0) lat_seen = c;
      end
      if (cpu_if.ERR) begin
        err_cnt++;
        if (lat_seen == 0) lat_seen = c;
      end
      @(negedge clk);
    end
    checkOutput($sformatf("v%0d_latency", idx), 32'(lat_seen), 32'(v.exp_lat));
    checkOutput($sformatf("v%0d_strobe_cycles", idx), 32'(low_seen), 32'(v.exp_low));
    checkOutput($sformatf("v%0d_wrong_strobe", idx), 32'(wrong), 32'd0);
    checkOutput($sformatf("v%0d_ack_count", idx), 32'(ack_cnt), v.exp_err ? 32'd0 : 32'd1);
    checkOutput($sformatf("v%0d_err_count", idx), 32'(err_cnt), v.exp_err ? 32'd1 : 32'd0);
    checkOutput($sformatf("v%0d_out", idx), cpu_if.OUT, v.exp_out);
    if (v.chk_addr) checkOutput($sformatf("v%0d_dev_addr", idx), 32'(dev_addr), 32'(v.exp_addr));
    if (v.we && !v.exp_err) checkOutput($sformatf("v%0d_dev_in", idx), dev_in, v.wdata);
  endtask

`ifdef MMU_ROUTER_ALIGN_CHECK_EN
  localparam logic [31:0] OUT_AFTER_V4 = DEV2_VAL;
`else
  localparam logic [31:0] OUT_AFTER_V4 = DEV0_VAL;
`endif

  int ack1, ack2, low_cnt, evt_cnt, idle_low;
  logic [31:0] out1, out2;

  initial begin
    vecs[0] = mk(1'b0, 32'h0001_0010, 32'h0,         1'b0, 1, 1, 2, DEV1_VAL, 1'b1, 14'h0004);
    vecs[1] = mk(1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 0, 4, 5, DEV1_VAL, 1'b1, 14'h0008);
    vecs[2] = mk(1'b0, 32'h0003_0000, 32'h0,         1'b1, 0, 0, 2, DEV1_VAL, 1'b0, 14'h0000);
    vecs[3] = mk(1'b0, 32'h0002_0100, 32'h0,         1'b0, 2, 6, 7, DEV2_VAL, 1'b1, 14'h0040);
`ifdef MMU_ROUTER_ALIGN_CHECK_EN
    vecs[4] = mk(1'b0, 32'h0000_0002, 32'h0,         1'b1, 0, 0, 2, DEV2_VAL, 1'b0, 14'h0000);
`else
    vecs[4] = mk(1'b0, 32'h0000_0002, 32'h0,         1'b0, 0, 4, 5, DEV0_VAL, 1'b1, 14'h0000);
`endif
    vecs[5] = mk(1'b0, 32'h0100_0000, 32'h0,         1'b1, 0, 0, 2, OUT_AFTER_V4, 1'b0, 14'h0000);
    vecs[6] = mk(1'b1, 32'h0001_FFFC, 32'hA5A5_5A5A, 1'b0, 1, 1, 2, OUT_AFTER_V4, 1'b1, 14'h3FFF);
    vecs[7] = mk(1'b0, 32'h0000_0004, 32'h0,         1'b0, 0, 4, 5, DEV0_VAL, 1'b1, 14'h0001);
    vecs[8] = mk(1'b0, 32'h0004_0000, 32'h0,         1'b1, 0, 0, 2, DEV0_VAL, 1'b0, 14'h0000);

    dev_out     = {DEV2_VAL, DEV1_VAL, DEV0_VAL};
    cpu_if.REQ  = 1'b0;
    cpu_if.WE   = 1'b0;
    cpu_if.ADDR = 32'h0;
    cpu_if.IN   = 32'h0;
    n_rst       = 1'b1;
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    mon_en = 1'b1;

    checkOutput("rst_ack", 32'(cpu_if.ACK), 32'd0);
    checkOutput("rst_err", 32'(cpu_if.ERR), 32'd0);
    checkOutput("rst_out", cpu_if.OUT, 32'd0);
    checkOutput("rst_n_we", 32'(dev_n_we), 32'h7);
    checkOutput("rst_n_oe", 32'(dev_n_oe), 32'h7);
    checkOutput("rst_dev_addr", 32'(dev_addr), 32'd0);
    checkOutput("rst_dev_in", dev_in, 32'd0);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // Reset during the second strobe cycle of a 6-cycle device-2 read.
    @(negedge clk);
    cpu_if.REQ  = 1'b1;
    cpu_if.WE   = 1'b0;
    cpu_if.ADDR = 32'h0002_0000;
    @(negedge clk);
    cpu_if.REQ = 1'b0;
    @(negedge clk);
    checkOutput("abort_strobe_before", 32'(dev_n_oe), 32'h3);
    n_rst = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    checkOutput("abort_n_oe", 32'(dev_n_oe), 32'h7);
    checkOutput("abort_n_we", 32'(dev_n_we), 32'h7);
    checkOutput("abort_out", cpu_if.OUT, 32'd0);
    evt_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (cpu_if.ACK || cpu_if.ERR || dev_n_oe != '1 || dev_n_we != '1) evt_cnt++;
      @(negedge clk);
    end
    checkOutput("abort_quiet", 32'(evt_cnt), 32'd0);

    // REQ held high: device 0 read (wait 3) then device 1 read (wait 0).
    cpu_if.REQ  = 1'b1;
    cpu_if.WE   = 1'b0;
    cpu_if.ADDR = 32'h0000_0008;
    @(negedge clk);
    cpu_if.ADDR = 32'h0001_000C;
    ack1 = 0; ack2 = 0; low_cnt = 0; idle_low = 0;
    out1 = 32'h0; out2 = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      if (dev_n_we != '1 || dev_n_oe != '1) begin
        low_cnt++;
        if (c == 6) idle_low = 1;
      end
      if (cpu_if.ACK) begin
        if (ack1 == 0) begin
          ack1 = c; out1 = cpu_if.OUT;
        end else if (ack2 == 0) begin
          ack2 = c; out2 = cpu_if.OUT; cpu_if.REQ = 1'b0;
        end
      end
      @(negedge clk);
    end
    cpu_if.REQ = 1'b0;
    checkOutput("b2b_ack1_cycle", 32'(ack1), 32'd5);
    checkOutput("b2b_ack2_cycle", 32'(ack2), 32'd8);
    checkOutput("b2b_out1", out1, DEV0_VAL);
    checkOutput("b2b_out2", out2, DEV1_VAL);
    checkOutput("b2b_strobe_cycles", 32'(low_cnt), 32'd5);
    checkOutput("b2b_idle_gap", 32'(idle_low), 32'd0);
    checkOutput("b2b_dev_addr", 32'(dev_addr), 32'h0003);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish within 200000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mmu_router.md
MMU_ROUTER -- requirements
Module: mmu_router

Interface
REQ-001 Parameter NUM_DEV, default 2, meaning number of memory-mapped devices, legal range 1..8.
REQ-002 Parameter DATA_W, default 32, meaning data bus width in bits.
REQ-003 Parameter SEL_LSB, default 16, meaning lowest ADDR bit of the device-select field; field width SEL_W = max(1, clog2(NUM_DEV)).
REQ-004 Parameter WAIT, default all zero, meaning packed NUM_DEV x 4-bit per-device wait-state counts.
REQ-005 CLK  in  1  system clock, all state updates on rising edge.
REQ-006 N_RST  in  1  reset, synchronous, active-high.
REQ-007 REQ  in  1  CPU access request, sampled only in IDLE.
REQ-008 WE  in  1  1 = write, 0 = read; latched with REQ.
REQ-009 ADDR  in  32  CPU byte address; latched with REQ.
REQ-010 IN  in  DATA_W  CPU write data; latched with REQ.
REQ-011 OUT  out  DATA_W  read data, held stable from ACK until next ACK.
REQ-012 ACK  out  1  one-cycle completion pulse.
REQ-013 ERR  out  1  one-cycle error pulse, replaces ACK for a failed access.
REQ-014 DEV_N_WE / DEV_N_OE  out  NUM_DEV each  active-low per-device strobes.
REQ-015 DEV_ADDR  out  SEL_LSB-2  latched word address ADDR[SEL_LSB-1:2].
REQ-016 DEV_IN  out  DATA_W  latched write data, shared by all devices.
REQ-017 DEV_OUT  in  NUM_DEV*DATA_W  per-device read data, device i at bits [i*DATA_W +: DATA_W].

Function
REQ-018 States: IDLE, ACCESS, DONE, FAULT; one access in flight at a time.
REQ-019 IDLE with REQ=1: latch WE/ADDR/IN, decode sel = ADDR[SEL_LSB +: SEL_W], load wait counter with WAIT[sel], go ACCESS; if sel >= NUM_DEV or any ADDR bit above the select field is 1, go FAULT instead.
REQ-020 ACCESS: exactly one strobe of device sel low (DEV_N_WE if WE else DEV_N_OE); counter decrements each cycle; at counter==0 capture DEV_OUT[sel] into OUT on reads, go DONE.
REQ-021 DONE: all strobes high, ACK=1 for one cycle, return to IDLE; REQ seen in DONE is ignored.
REQ-022 FAULT: no strobe asserted, ERR=1 for one cycle, OUT unchanged, return to IDLE.
REQ-023 Latency: REQ sampled at edge n -> strobe low for WAIT[sel]+1 cycles -> ACK high in cycle n+WAIT[sel]+2.
REQ-024 Writes never modify OUT.
REQ-025 At most one bit of DEV_N_WE|DEV_N_OE low in any cycle; never both strobes of one device low.
REQ-026 REQ held high continuously yields back-to-back accesses, each starting in the IDLE cycle after DONE/FAULT.

Reset
REQ-027 N_RST=1 at a rising edge forces IDLE, all strobes high, ACK=0, ERR=0, OUT=0, counter=0, latched address/data=0.
REQ-028 Reset mid-ACCESS aborts the access: strobes high in the following cycle, no ACK or ERR for the aborted access.

Configuration
REQ-029 Macro MMU_ROUTER_ALIGN_CHECK_EN defined: ADDR[1:0]!=0 at REQ goes to FAULT; undefined: ADDR[1:0] ignored, access proceeds on the word address.

Structure
REQ-030 Package mmu_router_pkg holds the state enum, MAX_DEV=8, and the 4-bit wait-count type.
REQ-031 One sub-module, mmu_router_decode: combinational sel/valid/aligned decode from ADDR, instantiated once.

Verification
REQ-032 NUM_DEV=2, WAIT=0: read 0x0001_0010, DEV_OUT[1]=0xDEADBEEF -> DEV_N_OE[1] low 1 cycle, DEV_ADDR=0x0004, ACK at n+2, OUT=0xDEADBEEF.
REQ-033 WAIT[0]=3: write 0x0000_0020 data 0x12345678 -> DEV_N_WE[0] low 4 cycles, DEV_IN=0x12345678, ACK at n+5, OUT unchanged.
REQ-034 NUM_DEV=3: read 0x0003_0000 (sel=3) -> no strobe, ERR at n+2, ACK never asserted.
REQ-035 N_RST=1 during cycle 2 of a WAIT=5 read -> strobes high next cycle, no ACK/ERR, OUT=0.
REQ-036 REQ held high, two reads to devices 0 then 1 -> ACKs separated by one IDLE cycle, strobes never overlap.
REQ-037 With MMU_ROUTER_ALIGN_CHECK_EN: read 0x0000_0002 -> ERR, no strobe; without it: ACK, DEV_ADDR=0x0000.
